flit_arb_buffer_bank: RTL and testbench

- Bank of N flit FIFOs with one steered write port and one arbitrated read port.
- Write side: a binary channel index is decoded to one-hot and pushes the incoming flit into the selected FIFO.
- Read side: a round-robin arbiter picks among non-empty FIFOs and emits one flit per cycle, tagged with its channel index.
- Sits between a chip-level serial link and the per-connection NoC ports, in both the inbound and outbound muxing paths.

---
 rtl/flit_arb_buffer_bank_pkg.sv | 24 ++
 rtl/flit_arb_buffer_bank_flit_fifo.sv | 66 ++++++
 rtl/flit_arb_buffer_bank_rr_arbiter.sv | 48 ++++
 rtl/flit_arb_buffer_bank.sv | 78 +++++++
 tb/tb_flit_arb_buffer_bank.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/flit_arb_buffer_bank_pkg.sv
// Shared helpers for the flit buffer bank: width derivation for channel indices.
package flit_arb_buffer_bank_pkg;

  // Ceiling log2, never less than 1 so a single-bit index survives N=1 or N=2.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    if (n <= 2) return 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int sel_width(input int n);
    int w;
    w = clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/flit_arb_buffer_bank_flit_fifo.sv
// One channel FIFO: circular memory, wrapping pointers, registered pop output.
module flit_fifo #(
  parameter int FW = 64,
  parameter int B  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [FW-1:0] data_i,
  output logic          not_empty_o,
  output logic          full_o,
  output logic [FW-1:0] data_o
);
  localparam int DEPTH = 1 << B;

  logic [FW-1:0] mem_q [DEPTH];
  logic [B-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [B:0]    cnt_q, cnt_d;
  logic [FW-1:0] data_q, data_d;
  logic          do_wr, do_rd;

  assign full_o      = (cnt_q == (B+1)'(DEPTH));
  assign not_empty_o = (cnt_q != '0);
  assign data_o      = data_q;

  // A pop in the same cycle frees the slot, so a push to a full FIFO is then legal.
  assign do_rd = pop_i && not_empty_o;
  assign do_wr = push_i && (!full_o || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = mem_q[rd_ptr_q];
    end
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/flit_arb_buffer_bank_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances only on consume.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int SELW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_i,
  input  logic            consume_i,
  output logic [N-1:0]    grant_o,
  output logic [SELW-1:0] grant_idx_o
);
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    grant;
  logic [SELW-1:0] gidx;
  logic            found;
  int              j;

  assign grant_o     = grant;
  assign grant_idx_o = gidx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    j     = 0;
    for (int o = 0; o < N; o++) begin
      j = (int'(ptr_q) + o) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        gidx     = SELW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found && consume_i)
      ptr_d = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/flit_arb_buffer_bank.sv
// Bank of per-channel flit FIFOs: steered write port, round-robin arbitrated read port.
module flit_arb_buffer_bank
  import flit_arb_buffer_bank_pkg::*;
#(
  parameter int  FW      = 64,
  parameter int  B       = 4,
  parameter int  CONNECT = 2,
  localparam int SELW    = sel_width(CONNECT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [SELW-1:0]    wr_sel_i,
  input  logic [FW-1:0]      wr_data_i,
  input  logic               rd_stall_i,
  output logic [CONNECT-1:0] grant_o,
  output logic [CONNECT-1:0] pop_o,
  output logic [CONNECT-1:0] not_empty_o,
  output logic [CONNECT-1:0] full_o,
  output logic               rd_valid_o,
  output logic [SELW+FW-1:0] rd_data_o
);
  logic [CONNECT-1:0] wr_onehot;
  logic [FW-1:0]      fifo_dout [CONNECT];
  logic [SELW-1:0]    gidx;
  logic               rd_valid_q, rd_valid_d;
  logic [SELW-1:0]    idx_q, idx_d;

  // Indices at or beyond CONNECT match no bit, so such writes vanish.
  always_comb begin
    wr_onehot = '0;
    for (int i = 0; i < CONNECT; i++)
      wr_onehot[i] = wr_en_i && (wr_sel_i == SELW'(i));
  end

  assign pop_o = grant_o & {CONNECT{~rd_stall_i}};

  for (genvar g = 0; g < CONNECT; g++) begin : g_fifo
    flit_fifo #(.FW(FW), .B(B)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (wr_onehot[g]),
      .pop_i       (pop_o[g]),
      .data_i      (wr_data_i),
      .not_empty_o (not_empty_o[g]),
      .full_o      (full_o[g]),
      .data_o      (fifo_dout[g])
    );
  end

  rr_arbiter #(.N(CONNECT), .SELW(SELW)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (not_empty_o),
    .consume_i   (~rd_stall_i),
    .grant_o     (grant_o),
    .grant_idx_o (gidx)
  );

  always_comb begin
    rd_valid_d = |pop_o;
    idx_d      = (|pop_o) ? gidx : idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      idx_q      <= idx_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = {idx_q, fifo_dout[idx_q]};

endmodule

// File: tb/tb_flit_arb_buffer_bank.sv
// Bench for flit_arb_buffer_bank (FW=64, B=2, two channels): vector table, directed corners, random traffic.
module tb_flit_arb_buffer_bank;
  localparam int FW = 64;
  localparam int B  = 2;
  localparam int N  = 2;
  localparam int W  = FW + 1;
  localparam int DEPTH = 1 << B;

  logic          clk, rst_n;
  logic          wr_en_i, wr_sel_i, rd_stall_i;
  logic [FW-1:0] wr_data_i;
  logic [N-1:0]  grant_o, pop_o, not_empty_o, full_o;
  logic          rd_valid_o;
  logic [W-1:0]  rd_data_o;

  flit_arb_buffer_bank #(.FW(FW), .B(B), .CONNECT(N)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
    .wr_data_i(wr_data_i), .rd_stall_i(rd_stall_i), .grant_o(grant_o),
    .pop_o(pop_o), .not_empty_o(not_empty_o), .full_o(full_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [FW-1:0] mq [N][$];
  logic [W-1:0]  exp_q[$];
  int            rr_ptr = 0;
  logic          pend = 1'b0;

  // Snapshot of DUT outputs at the last check point
  logic [N-1:0]  s_grant, s_pop;
  logic          s_valid;
  logic [W-1:0]  s_data;

  typedef struct {
    logic          we;
    logic          sel;
    logic [FW-1:0] data;
    logic          stall;
    logic [N-1:0]  exp_grant;
    logic          exp_valid;
    logic [W-1:0]  exp_data;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_flag_ne();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = (mq[i].size() > 0);
    return f;
  endfunction

  function automatic logic [N-1:0] model_flag_full();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = (mq[i].size() == DEPTH);
    return f;
  endfunction

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic cycle(input logic we, input logic sel, input logic [FW-1:0] d, input logic st);
    logic [N-1:0] mg;
    int k;
    wr_en_i = we; wr_sel_i = sel; wr_data_i = d; rd_stall_i = st;
    @(negedge clk);
    mg = '0; k = -1;
    for (int o = 0; o < N; o++) begin
      int jj;
      jj = (rr_ptr + o) % N;
      if (k < 0 && mq[jj].size() > 0) begin k = jj; mg[jj] = 1'b1; end
    end
    s_grant = grant_o; s_pop = pop_o; s_valid = rd_valid_o; s_data = rd_data_o;
    check("grant", grant_o, mg);
    check("pop", pop_o, st ? '0 : mg);
    check("not_empty", not_empty_o, model_flag_ne());
    check("full", full_o, model_flag_full());
    check("rd_valid", rd_valid_o, pend);
    if (pend) begin
      if (exp_q.size() == 0) check("rd_data_queue_empty", 1, 0);
      else check("rd_data", rd_data_o, exp_q.pop_front());
    end
    pend = 1'b0;
    if (k >= 0 && !st) begin
      exp_q.push_back({k[0], mq[k].pop_front()});
      rr_ptr = (k + 1) % N;
      pend = 1'b1;
    end
    if (we && mq[sel].size() < DEPTH) mq[sel].push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en_i = 1'b0; wr_sel_i = 1'b0; wr_data_i = '0; rd_stall_i = 1'b0;
    #2;
    check("rst_not_empty", not_empty_o, 2'b00);
    check("rst_full", full_o, 2'b00);
    check("rst_grant", grant_o, 2'b00);
    check("rst_pop", pop_o, 2'b00);
    check("rst_rd_valid", rd_valid_o, 1'b0);
    check("rst_rd_data", rd_data_o, '0);
    for (int i = 0; i < N; i++) mq[i].delete();
    exp_q.delete();
    rr_ptr = 0; pend = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en_i = 1'b0; wr_sel_i = 1'b0; wr_data_i = '0; rd_stall_i = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Single flit and interleaved two-channel traffic
    vecs[0] = '{1'b1, 1'b1, 64'hA5, 1'b0, 2'b00, 1'b0, '0};
    vecs[1] = '{1'b0, 1'b0, 64'h0,  1'b0, 2'b10, 1'b0, '0};
    vecs[2] = '{1'b0, 1'b0, 64'h0,  1'b0, 2'b00, 1'b1, {1'b1, 64'hA5}};
    vecs[3] = '{1'b1, 1'b0, 64'h11, 1'b0, 2'b00, 1'b0, '0};
    vecs[4] = '{1'b1, 1'b1, 64'h22, 1'b0, 2'b01, 1'b0, '0};
    vecs[5] = '{1'b0, 1'b0, 64'h0,  1'b0, 2'b10, 1'b1, {1'b0, 64'h11}};
    vecs[6] = '{1'b0, 1'b0, 64'h0,  1'b0, 2'b00, 1'b1, {1'b1, 64'h22}};
    vecs[7] = '{1'b0, 1'b0, 64'h0,  1'b0, 2'b00, 1'b0, '0};
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].we, vecs[i].sel, vecs[i].data, vecs[i].stall);
      check($sformatf("vec%0d_grant", i), s_grant, vecs[i].exp_grant);
      check($sformatf("vec%0d_valid", i), s_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), s_data, vecs[i].exp_data);
    end

    // Round-robin: 3 flits per channel preloaded under stall, then drained
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 64'h100 + 64'(i), 1'b1);
      cycle(1'b1, 1'b1, 64'h200 + 64'(i), 1'b1);
    end
    begin
      int idx_seen;
      idx_seen = 0;
      for (int c = 0; c < 8; c++) begin
        cycle(1'b0, 1'b0, '0, 1'b0);
        if (s_valid) begin
          check("rr_index_order", s_data[FW], idx_seen[0]);
          idx_seen++;
        end
      end
      check("rr_count", idx_seen, 6);
    end

    // Stall holds grant and blocks pops, then output resumes in order
    do_reset();
    cycle(1'b1, 1'b0, 64'hC0, 1'b1);
    cycle(1'b1, 1'b1, 64'hC1, 1'b1);
    cycle(1'b1, 1'b0, 64'hC2, 1'b1);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      check("stall_grant_hold", s_grant, 2'b01);
      check("stall_pop_zero", s_pop, 2'b00);
    end
    for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, '0, 1'b0);

    // Full and wrap on channel 0: 5th push dropped, then streaming push/pop
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 64'hF0 + 64'(i), 1'b1);
    check("full_after_4", full_o, 2'b01);
    for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 64'hE0 + 64'(i), 1'b0);
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, '0, 1'b0);

    // Push and pop together on a full FIFO
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 64'hD0 + 64'(i), 1'b1);
    cycle(1'b1, 1'b0, 64'hDD, 1'b0);
    check("full_kept_after_pushpop", full_o, 2'b01);
    for (int c = 0; c < 6; c++) cycle(1'b0, 1'b0, '0, 1'b0);

    // Asynchronous reset with data in flight
    cycle(1'b1, 1'b0, 64'h77, 1'b0);
    cycle(1'b1, 1'b1, 64'h78, 1'b1);
    do_reset();
    cycle(1'b0, 1'b0, '0, 1'b0);

    // Random traffic
    for (int c = 0; c < 300; c++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
    for (int c = 0; c < 12; c++) cycle(1'b0, 1'b0, '0, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
